// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage. It holds the PC and fetches one word at a time from
//   instruction memory over a req/ready handshake. It presents the fetched word
//   until the core signals advance, then loads the next PC, which can be
//   sequential, a taken branch, or a jump.
//
// Ports
//   clk, reset_n                 rising-edge clock, asynchronous active-low reset
//   imem_req/imem_addr           registered fetch request; the address is always pc
//   imem_ready/imem_rdata        memory response, accepted only while requesting
//   instr/instr_valid            held instruction and its valid flag
//   advance/pcsrc/jump/signimm   retirement strobe and next-PC controls,
//                                sampled only while an instruction is held
//   pc/pcplus4                   current PC and its sequential successor
//   retired                      count of retired instructions, wraps at 2^32
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        advance,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic [31:0] signimm,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic [31:0] retired
);

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;

  logic [31:0] pcplus4_w;
  logic [31:0] next_pc_raw;
  logic [31:0] next_pc;

  assign pcplus4_w = pc_q + 32'd4;

  // Jump takes priority over a taken branch. The branch offset is the word
  // offset scaled to bytes, and the add wraps modulo 2^32.
  always_comb begin
    next_pc_raw = pcplus4_w;
    if (jump) begin
      next_pc_raw = {pcplus4_w[31:28], instr_q[25:0], 2'b00};
    end else if (pcsrc) begin
      next_pc_raw = pcplus4_w + (signimm << 2);
    end
  end

  assign next_pc = next_pc_raw & 32'hFFFF_FFFC;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    retired_d     = retired_q;
    imem_req_d    = imem_req_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      IDLE: begin
        state_d    = REQ;
        imem_req_d = 1'b1;
      end
      REQ: begin
        if (imem_ready) begin
          state_d       = HOLD;
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
        end
      end
      HOLD: begin
        if (advance) begin
          state_d       = REQ;
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          retired_d     = retired_q + 32'd1;
        end
      end
      default: begin
        state_d       = IDLE;
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC_ALIGNED;
      instr_q       <= 32'd0;
      retired_q     <= 32'd0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      retired_q     <= retired_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign pcplus4     = pcplus4_w;
  assign retired     = retired_q;

endmodule
